// File: rtl/int_ctrl.sv
// Interrupt controller: synchronizes N async sources, latches (edge) or passes (level) them,
// masks them, and presents registered INT/CAUSE plus a Wishbone register window.
module int_ctrl #(
    parameter int unsigned N = 6
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] src,
    input  logic         STB,
    input  logic         WE,
    input  logic [31:0]  ADDR,
    input  logic [31:0]  DAT_I,
    output logic [31:0]  DAT_O,
    output logic         ACK,
    output logic         INT,
    output logic [31:0]  CAUSE
);

    typedef enum logic {StIdle, StHold} state_e;

    state_e       state_q, state_d;
    logic [N-1:0] s0_q, s1_q, s2_q;
    logic [N-1:0] pend_q, pend_d;
    logic [N-1:0] mask_q, mask_d;
    logic [N-1:0] edge_q, edge_d;
    logic [31:0]  dat_o_q, dat_o_d;
    logic         ack_q, ack_d;
    logic         int_q, int_d;
    logic [4:0]   cause_q, cause_d;

    logic [N-1:0] act, rise, w1c;
    logic [31:0]  rd_data;
    logic         access, wr;
    logic         unused_bus;

    assign unused_bus = ^{ADDR, DAT_I};

    always_comb begin
        act     = pend_q & mask_q;
        rise    = s1_q & ~s2_q;
        access  = (state_q == StIdle) && STB;
        wr      = access && WE;

        // Reverse scan so the lowest active index wins.
        cause_d = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (act[i]) cause_d = 5'(i);
        end
        int_d = |act;

        rd_data = '0;
        case (ADDR[3:2])
            2'd0: rd_data[N-1:0] = pend_q;
            2'd1: rd_data[N-1:0] = mask_q;
            2'd2: rd_data        = {int_q, 26'b0, cause_q};
            2'd3: rd_data[N-1:0] = edge_q;
        endcase

        w1c    = (wr && ADDR[3:2] == 2'd0) ? DAT_I[N-1:0] : '0;
        mask_d = (wr && ADDR[3:2] == 2'd1) ? DAT_I[N-1:0] : mask_q;
        edge_d = (wr && ADDR[3:2] == 2'd3) ? DAT_I[N-1:0] : edge_q;

        // Edge bits: a new rise beats a simultaneous W1C. Level bits track s1.
        pend_d = (edge_q & ((pend_q & ~w1c) | rise)) | (~edge_q & s1_q);

        state_d = state_q;
        case (state_q)
            StIdle: if (STB)  state_d = StHold;
            StHold: if (!STB) state_d = StIdle;
        endcase
        ack_d   = (state_d == StHold);
        dat_o_d = access ? rd_data : dat_o_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
            s0_q    <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            edge_q  <= '1;
            dat_o_q <= '0;
            ack_q   <= 1'b0;
            int_q   <= 1'b0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            s0_q    <= src;
            s1_q    <= s0_q;
            s2_q    <= s1_q;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            edge_q  <= edge_d;
            dat_o_q <= dat_o_d;
            ack_q   <= ack_d;
            int_q   <= int_d;
            cause_q <= cause_d;
        end
    end

    assign DAT_O = dat_o_q;
    assign ACK   = ack_q;
    assign INT   = int_q;
    assign CAUSE = {27'b0, cause_q};

endmodule
